// File: rtl/servo_pulse_decoder.sv
// Hobby-servo PWM receiver: measures pulse width in us, validates the frame period,
// and reports width plus a 0..180 degree angle from an exact serial divider.
module servo_pulse_decoder #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int TICK_DIV      = CLK_HZ / 1_000_000,
  parameter int MIN_US        = 500,
  parameter int MAX_US        = 2500,
  parameter int PERIOD_US     = 20000,
  parameter int PERIOD_TOL_US = 2000,
  parameter int TIMEOUT_US    = 25000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [11:0] width_us,
  output logic [7:0]  angle,
  output logic        valid,
  output logic        signal_lost,
  output logic [7:0]  err_cnt
);

  localparam int CNTW = 15;
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SPAN = MAX_US - MIN_US;
  localparam int NUMW = $clog2(SPAN * 180 + 1);
  localparam int REMW = $clog2(SPAN) + 1;
  localparam int CW   = $clog2(NUMW);

  typedef enum logic [1:0] {S_WAIT_LOW, S_LOW, S_HIGH} state_t;

  state_t            r_state, w_state_nx;
  logic [1:0]        r_sync;
  logic              r_pwm_d;
  logic [PW-1:0]     r_pre;
  logic [CNTW-1:0]   r_us;
  logic              r_period_ok, r_prev_rise;
  logic              r_busy;
  logic [CW-1:0]     r_cnt;
  logic [NUMW-1:0]   r_num;
  logic [REMW-1:0]   r_rem;
  logic [7:0]        r_quo;
  logic [11:0]       r_wlat;

  logic w_rise, w_fall, w_tick, w_tmo, w_period_good, w_in_range;
  logic w_eval, w_start, w_err_inc, w_tmo_evt, w_ge, w_done;
  logic [REMW-1:0]   w_trial;
  logic [NUMW-1:0]   w_num;

  // Synchronizer is deliberately not reset so a pin held high through reset
  // is seen as high (not as a fresh rising edge) when reset releases.
  always_ff @(posedge CLOCK_50) begin
    r_sync  <= {r_sync[0], pwm_in};
    r_pwm_d <= r_sync[1];
  end

  assign w_rise = r_sync[1] & ~r_pwm_d;
  assign w_fall = ~r_sync[1] & r_pwm_d;
  assign w_tick = (r_pre == PW'(TICK_DIV - 1));
  assign w_tmo  = (r_us == CNTW'(TIMEOUT_US));

  // The edge cycle counts as the first elapsed cycle, so a pulse of exactly
  // N*TICK_DIV cycles reads back as N us.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_pre <= '0;
      r_us  <= '0;
    end else if (w_rise) begin
      r_pre <= (TICK_DIV == 1) ? PW'(0) : PW'(1);
      r_us  <= (TICK_DIV == 1) ? CNTW'(1) : CNTW'(0);
    end else begin
      r_pre <= w_tick ? PW'(0) : r_pre + PW'(1);
      if (w_tick && !w_tmo) r_us <= r_us + CNTW'(1);
    end
  end

  assign w_period_good = (r_us >= CNTW'(PERIOD_US - PERIOD_TOL_US)) &&
                         (r_us <= CNTW'(PERIOD_US + PERIOD_TOL_US));
  assign w_in_range    = (r_us >= CNTW'(MIN_US)) && (r_us <= CNTW'(MAX_US));

  always_comb begin
    w_state_nx = r_state;
    w_eval     = 1'b0;
    w_start    = 1'b0;
    w_err_inc  = 1'b0;
    w_tmo_evt  = 1'b0;
    case (r_state)
      S_WAIT_LOW: if (!r_sync[1]) w_state_nx = S_LOW;
      S_LOW: begin
        if (w_rise) begin
          w_eval     = 1'b1;
          w_err_inc  = r_prev_rise && !w_period_good;
          w_state_nx = S_HIGH;
        end else if (w_tmo) begin
          w_tmo_evt  = 1'b1;
        end
      end
      S_HIGH: begin
        if (w_fall) begin
          w_state_nx = S_LOW;
          w_start    = r_period_ok && w_in_range;
          w_err_inc  = r_period_ok && !w_in_range;
        end else if (w_tmo) begin
          w_tmo_evt  = 1'b1;
          w_state_nx = S_WAIT_LOW;
        end
      end
      default: w_state_nx = S_WAIT_LOW;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= S_WAIT_LOW;
      r_period_ok <= 1'b0;
      r_prev_rise <= 1'b0;
      signal_lost <= 1'b1;
      err_cnt     <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_eval) begin
        r_period_ok <= r_prev_rise && w_period_good;
        r_prev_rise <= 1'b1;
      end
      if (w_tmo_evt) begin
        signal_lost <= 1'b1;
        r_period_ok <= 1'b0;
        r_prev_rise <= 1'b0;
      end else if (w_done) begin
        signal_lost <= 1'b0;
      end
      if (w_err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Restoring division of (w-MIN)*180 by SPAN, one numerator bit per cycle.
  assign w_num   = NUMW'((32'(r_us) - 32'(MIN_US)) * 32'd180);
  assign w_trial = {r_rem[REMW-2:0], r_num[NUMW-1]};
  assign w_ge    = (w_trial >= REMW'(SPAN));
  assign w_done  = r_busy && (r_cnt == CW'(NUMW - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_num    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_wlat   <= '0;
      valid    <= 1'b0;
      width_us <= '0;
      angle    <= '0;
    end else begin
      valid <= 1'b0;
      if (w_start) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
        r_num  <= w_num;
        r_rem  <= '0;
        r_quo  <= '0;
        r_wlat <= r_us[11:0];
      end else if (r_busy) begin
        r_num <= r_num << 1;
        r_rem <= w_ge ? (w_trial - REMW'(SPAN)) : w_trial;
        r_quo <= {r_quo[6:0], w_ge};
        r_cnt <= r_cnt + CW'(1);
        if (w_done) begin
          r_busy   <= 1'b0;
          valid    <= 1'b1;
          width_us <= r_wlat;
          angle    <= {r_quo[6:0], w_ge};
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Scoreboard bench for servo_pulse_decoder on a time-compressed parameter set
// (2 clocks per us, 600 us frames) so every scenario runs in a few thousand cycles.
module tb_servo_pulse_decoder;
  localparam int TD   = 2;
  localparam int MINU = 20;
  localparam int MAXU = 220;
  localparam int PER  = 600;
  localparam int TOL  = 60;
  localparam int TMO  = 750;

  logic        clk = 1'b0, rst = 1'b1, pwm = 1'b0;
  logic [11:0] width_us;
  logic [7:0]  angle, err_cnt;
  logic        valid, signal_lost;

  servo_pulse_decoder #(
    .CLK_HZ(2_000_000), .TICK_DIV(TD), .MIN_US(MINU), .MAX_US(MAXU),
    .PERIOD_US(PER), .PERIOD_TOL_US(TOL), .TIMEOUT_US(TMO)
  ) dut (
    .CLOCK_50(clk), .reset(rst), .pwm_in(pwm), .width_us(width_us), .angle(angle),
    .valid(valid), .signal_lost(signal_lost), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int w; int a; } exp_t;
  exp_t q[$];
  int  n_chk = 0, n_fail = 0;
  bit  m_prev = 0;
  int  m_gap = 0, exp_err = 0, last_w = 0, t_rise = 0, t_fall = 0;

  // Scoreboard monitor: every valid must match the oldest expected report.
  always @(negedge clk) begin
    if (!rst && valid) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got width=%0d angle=%0d, want no report", width_us, angle);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (width_us !== 12'(e.w) || angle !== 8'(e.a)) begin
          n_fail++;
          $display("FAIL report: got width=%0d angle=%0d, want width=%0d angle=%0d",
                   width_us, angle, e.w, e.a);
        end
      end
      n_chk++;
      if (signal_lost !== 1'b0) begin
        n_fail++;
        $display("FAIL lost_at_valid: got %0b want 0", signal_lost);
      end
      n_chk++;
      if (cyc - t_fall > 43) begin
        n_fail++;
        $display("FAIL latency: got %0d cycles want <= 43", cyc - t_fall);
      end
    end
  end

  initial begin
    #(150000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic drive_pulse(input int w, input int gap);
    @(posedge clk); #1 pwm = 1'b1; t_rise = cyc;
    repeat (w * TD) @(posedge clk);
    #1 pwm = 1'b0; t_fall = cyc;
    repeat ((gap - w) * TD - 1) @(posedge clk);
  endtask

  task automatic send_pulse(input int w, input int gap);
    bit ok;
    ok = m_prev && ((m_gap > PER ? m_gap - PER : PER - m_gap) <= TOL);
    if (m_prev && !ok) bump_err();
    m_prev = 1; m_gap = gap;
    if (ok && w >= MINU && w <= MAXU) begin
      q.push_back('{w, (w - MINU) * 180 / (MAXU - MINU)});
      last_w = w;
    end else if (ok) begin
      bump_err();
    end
    drive_pulse(w, gap);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    m_prev = 0; exp_err = 0; last_w = 0; q.delete();
  endtask

  task automatic chk_err_q(input string tag);
    @(negedge clk);
    n_chk++;
    if (err_cnt !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL %s_err_cnt: got %0d want %0d", tag, err_cnt, exp_err);
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_valid: got %0d outstanding want 0", tag, q.size());
    end
  endtask

  task automatic chk_lost(input string tag, input logic want);
    @(negedge clk);
    n_chk++;
    if (signal_lost !== want) begin
      n_fail++;
      $display("FAIL %s: got signal_lost=%0b want %0b", tag, signal_lost, want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk += 5;
    if (width_us !== 12'd0) begin n_fail++; $display("FAIL rst_width: got %0d want 0", width_us); end
    if (angle !== 8'd0) begin n_fail++; $display("FAIL rst_angle: got %0d want 0", angle); end
    if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", valid); end
    if (signal_lost !== 1'b1) begin n_fail++; $display("FAIL rst_lost: got %0b want 1", signal_lost); end
    if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_first_report();
    repeat (20) @(posedge clk);
    send_pulse(120, PER);
    chk_lost("first_pulse_lost", 1'b1);
    send_pulse(120, PER);
    chk_lost("second_pulse_lost", 1'b0);
    chk_err_q("first_report");
  endtask

  task automatic test_widths();
    int ws[5] = '{MINU, MAXU, 45, 121, 120};
    foreach (ws[i]) send_pulse(ws[i], PER);
    chk_err_q("widths");
  endtask

  task automatic test_range_err();
    int ws[4] = '{230, 221, 19, 120};
    for (int i = 0; i < 4; i++) begin
      send_pulse(ws[i], PER);
      if (i < 3) begin
        @(negedge clk);
        n_chk++;
        if (width_us !== 12'(last_w)) begin
          n_fail++;
          $display("FAIL hold_width: got %0d want %0d", width_us, last_w);
        end
      end
    end
    chk_err_q("range_err");
  endtask

  task automatic test_period();
    repeat (3) send_pulse(120, PER / 2);
    chk_err_q("period_short");
    repeat (3) send_pulse(120, PER);
    chk_err_q("period_back");
  endtask

  task automatic test_period_bounds();
    int gs[5] = '{PER + TOL, PER - TOL, PER + TOL + 1, PER, PER};
    foreach (gs[i]) send_pulse(150, gs[i]);
    chk_err_q("period_bounds");
  endtask

  task automatic test_lost_low();
    int t0;
    send_pulse(120, PER);
    t0 = t_rise;
    while (cyc < t0 + TMO * TD + 2) @(negedge clk);
    n_chk++;
    if (signal_lost !== 1'b0) begin
      n_fail++; $display("FAIL lost_early: got %0b want 0", signal_lost);
    end
    @(negedge clk);
    n_chk++;
    if (signal_lost !== 1'b1) begin
      n_fail++; $display("FAIL lost_on_time: got %0b want 1", signal_lost);
    end
    m_prev = 0;
    chk_err_q("lost_low");
  endtask

  task automatic test_lost_high();
    send_pulse(120, PER);
    send_pulse(120, PER);
    chk_lost("relock", 1'b0);
    drive_pulse(900, 1000);
    m_prev = 0;
    chk_lost("held_high_lost", 1'b1);
    send_pulse(120, PER);
    chk_lost("recover_first", 1'b1);
    send_pulse(120, PER);
    chk_lost("recover_second", 1'b0);
    chk_err_q("lost_high");
  endtask

  task automatic test_reset_inflight();
    send_pulse(120, PER);
    @(posedge clk); #1 pwm = 1'b1;
    repeat (100 * TD) @(posedge clk);
    #1 pwm = 1'b0; t_fall = cyc;
    repeat (8) @(posedge clk);
    do_reset();
    repeat (60) @(negedge clk);
    n_chk += 2;
    if (width_us !== 12'd0) begin n_fail++; $display("FAIL inflight_width: got %0d want 0", width_us); end
    if (signal_lost !== 1'b1) begin n_fail++; $display("FAIL inflight_lost: got %0b want 1", signal_lost); end
    repeat (PER * TD) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    send_pulse(120, PER);
    send_pulse(120, PER);
    @(posedge clk); #1 pwm = 1'b1;
    repeat (100) @(posedge clk);
    do_reset();
    @(negedge clk);
    n_chk += 3;
    if (width_us !== 12'd0) begin n_fail++; $display("FAIL mid_width: got %0d want 0", width_us); end
    if (signal_lost !== 1'b1) begin n_fail++; $display("FAIL mid_lost: got %0b want 1", signal_lost); end
    if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_err: got %0d want 0", err_cnt); end
    repeat (100) @(posedge clk);
    #1 pwm = 1'b0; t_fall = cyc;
    repeat (400) @(posedge clk);
    send_pulse(120, PER);
    chk_lost("mid_first", 1'b1);
    send_pulse(150, PER);
    chk_err_q("reset_mid");
  endtask

  task automatic test_err_sat();
    repeat (260) send_pulse(10, 30);
    chk_err_q("err_sat");
  endtask

  initial begin
    test_reset();
    test_first_report();
    test_widths();
    test_range_err();
    test_period();
    test_period_bounds();
    test_lost_low();
    test_lost_high();
    test_reset_inflight();
    test_reset_mid();
    test_err_sat();
    repeat (50) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
